// File: rtl/multicycle_control.sv
// multicycle_control
// Sequencing FSM that runs the shared RISC-V datapath as a multi-cycle machine.
// Each instruction steps through FETCH, DECODE and one or more execute-class
// states. Mux selects and memory requests are registered from the next state,
// so they are glitch-free. Only pc_write and ir_write are qualified
// combinationally: by mem_ready in FETCH and by zero in BRANCH.
// The block also counts retired instructions and halts in TRAP on an
// unsupported opcode.

module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             memtoreg,
  output logic [1:0]       alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluop,
  output logic             pcsource,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  // Registered control word for one state. in_fetch and in_branch enable the
  // two handshake-qualified strobes.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       memtoreg;
    logic [1:0] alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       pcsource;
    logic       halted;
    logic       in_fetch;
    logic       in_branch;
  } ctrl_t;

  // Moore control word for each state. All strobes and selects default to 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read = 1'b1;
        c.alusrc_b = 2'd1;
        c.in_fetch = 1'b1;
      end
      DECODE: begin
        c.alusrc_a = 2'd2;
        c.alusrc_b = 2'd2;
      end
      EXEC_R: begin
        c.alusrc_a = 2'd1;
        c.aluop    = 2'd2;
      end
      EXEC_I, MEM_ADDR: begin
        c.alusrc_a = 2'd1;
        c.alusrc_b = 2'd2;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      WB_ALU: begin
        c.reg_write = 1'b1;
      end
      WB_MEM: begin
        c.reg_write = 1'b1;
        c.memtoreg  = 1'b1;
      end
      BRANCH: begin
        c.alusrc_a  = 2'd1;
        c.aluop     = 2'd1;
        c.pcsource  = 1'b1;
        c.in_branch = 1'b1;
      end
      TRAP: begin
        c.halted = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   retire;

  // Next-state selection and detection of an edge that completes an instruction.
  always_comb begin
    state_next = state_q;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:               state_next = EXEC_R;
          OP_IMM:             state_next = EXEC_I;
          OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
          OP_BRANCH:          state_next = BRANCH;
          default:            state_next = TRAP;
        endcase
      end
      EXEC_R, EXEC_I: begin
        state_next = WB_ALU;
      end
      MEM_ADDR: begin
        if (opcode == OP_LOAD)       state_next = MEM_RD;
        else if (opcode == OP_STORE) state_next = MEM_WR;
        else                         state_next = TRAP;
      end
      MEM_RD: begin
        if (mem_ready) state_next = WB_MEM;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      WB_ALU, WB_MEM, BRANCH: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = TRAP;
      end
    endcase
  end

  // Update the state, the registered control word and the retired counter.
  // The async reset forces the FETCH word, so write strobes drop at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      ctrl_q  <= decode_ctrl(FETCH);
      retired <= '0;
    end else begin
      state_q <= state_next;
      ctrl_q  <= decode_ctrl(state_next);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign iord      = ctrl_q.iord;
  assign reg_write = ctrl_q.reg_write;
  assign memtoreg  = ctrl_q.memtoreg;
  assign alusrc_a  = ctrl_q.alusrc_a;
  assign alusrc_b  = ctrl_q.alusrc_b;
  assign aluop     = ctrl_q.aluop;
  assign pcsource  = ctrl_q.pcsource;
  assign halted    = ctrl_q.halted;
  assign state     = state_q;

  // IR/PC loads happen only when the fetch completes, and never while reset is
  // held. A branch loads the PC only when the compare gives zero.
  assign ir_write = ctrl_q.in_fetch & mem_ready & rst;
  assign pc_write = (ctrl_q.in_fetch & mem_ready & rst) | (ctrl_q.in_branch & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed-vector bench for multicycle_control. A default-width instance and a
// CNT_W=4 instance share all inputs, so the retired-counter wrap can be seen.

module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write, memtoreg;
  logic [1:0]  alusrc_a, alusrc_b, aluop;
  logic        pcsource, halted;
  logic [3:0]  state;
  logic [15:0] retired;

  logic        s_pc_write, s_ir_write, s_iord, s_mem_read, s_mem_write, s_reg_write, s_memtoreg;
  logic [1:0]  s_alusrc_a, s_alusrc_b, s_aluop;
  logic        s_pcsource, s_halted;
  logic [3:0]  s_state;
  logic [3:0]  s_retired;

  int checks = 0;
  int errors = 0;

  multicycle_control u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .memtoreg(memtoreg),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .pcsource(pcsource),
    .halted(halted), .state(state), .retired(retired)
  );

  multicycle_control #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .ir_write(s_ir_write), .iord(s_iord), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .reg_write(s_reg_write), .memtoreg(s_memtoreg),
    .alusrc_a(s_alusrc_a), .alusrc_b(s_alusrc_b), .aluop(s_aluop), .pcsource(s_pcsource),
    .halted(s_halted), .state(s_state), .retired(s_retired)
  );

  // Free-running clock with a period of 10 time units.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic        pcw;
    logic        irw;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                              input logic [3:0] st, input logic pcw, input logic irw,
                              input logic [15:0] ret);
    vec_t v;
    v.rst_n = r; v.op = op; v.z = z; v.rdy = rdy;
    v.st = st; v.pcw = pcw; v.irw = irw; v.ret = ret;
    return v;
  endfunction

  // Hand-written control word per state. Bit order:
  // {iord, mem_read, mem_write, reg_write, memtoreg, alusrc_a, alusrc_b, aluop, pcsource, halted}
  function automatic logic [12:0] exp_ctrl(input logic [3:0] st);
    case (st)
      4'd0:    return 13'b0_1_0_0_0_00_01_00_0_0;
      4'd1:    return 13'b0_0_0_0_0_10_10_00_0_0;
      4'd2:    return 13'b0_0_0_0_0_01_00_10_0_0;
      4'd3:    return 13'b0_0_0_0_0_01_10_00_0_0;
      4'd4:    return 13'b0_0_0_0_0_01_10_00_0_0;
      4'd5:    return 13'b1_1_0_0_0_00_00_00_0_0;
      4'd6:    return 13'b1_0_1_0_0_00_00_00_0_0;
      4'd7:    return 13'b0_0_0_1_0_00_00_00_0_0;
      4'd8:    return 13'b0_0_0_1_1_00_00_00_0_0;
      4'd9:    return 13'b0_0_0_0_0_01_00_01_1_0;
      4'd15:   return 13'b0_0_0_0_0_00_00_00_0_1;
      default: return 13'h0;
    endcase
  endfunction

  // Drive one cycle's inputs shortly after the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst_n;
    opcode    = v.op;
    zero      = v.z;
    mem_ready = v.rdy;
    #1;
  endtask

  // Compare the full output set and both retired counters with the vector.
  task automatic checkOutput(input vec_t v, input string name);
    logic [18:0] act, exp;
    act = {state, pc_write, ir_write, iord, mem_read, mem_write, reg_write, memtoreg,
           alusrc_a, alusrc_b, aluop, pcsource, halted};
    exp = {v.st, v.pcw, v.irw, exp_ctrl(v.st)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp);
    end
    checks++;
    if (retired !== v.ret) begin
      errors++;
      $display("[TB] FAIL %s retired: got %0d expected %0d", name, retired, v.ret);
    end
    checks++;
    if (s_retired !== v.ret[3:0]) begin
      errors++;
      $display("[TB] FAIL %s retired4: got %0d expected %0d", name, s_retired, v.ret[3:0]);
    end
  endtask

  initial begin
    int rw_count;
    vec_t v;
    rst = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held for three cycles with mem_ready high
    for (int i = 0; i < 3; i++) begin
      v = mk(1'b0, 7'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0);
      applyStimulus(v);
      checkOutput(v, $sformatf("reset%0d", i));
    end

    // I-type, R-type, sw back to back (first vector releases reset)
    vecs.push_back(mk(1, 7'd19, 0, 1, 4'd0, 1, 1, 16'd0));
    vecs.push_back(mk(1, 7'd19, 0, 1, 4'd1, 0, 0, 16'd0));
    vecs.push_back(mk(1, 7'd19, 0, 0, 4'd3, 0, 0, 16'd0));
    vecs.push_back(mk(1, 7'd19, 0, 1, 4'd7, 0, 0, 16'd0));
    vecs.push_back(mk(1, 7'd51, 0, 1, 4'd0, 1, 1, 16'd1));
    vecs.push_back(mk(1, 7'd51, 0, 1, 4'd1, 0, 0, 16'd1));
    vecs.push_back(mk(1, 7'd51, 1, 1, 4'd2, 0, 0, 16'd1));
    vecs.push_back(mk(1, 7'd51, 1, 1, 4'd7, 0, 0, 16'd1));
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd0, 1, 1, 16'd2));
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd1, 0, 0, 16'd2));
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd4, 0, 0, 16'd2));
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd6, 0, 0, 16'd2));
    // lw with two wait cycles in MEM_RD
    vecs.push_back(mk(1, 7'd3,  0, 1, 4'd0, 1, 1, 16'd3));
    vecs.push_back(mk(1, 7'd3,  0, 1, 4'd1, 0, 0, 16'd3));
    vecs.push_back(mk(1, 7'd3,  0, 1, 4'd4, 0, 0, 16'd3));
    vecs.push_back(mk(1, 7'd3,  0, 0, 4'd5, 0, 0, 16'd3));
    vecs.push_back(mk(1, 7'd3,  0, 0, 4'd5, 0, 0, 16'd3));
    vecs.push_back(mk(1, 7'd3,  0, 1, 4'd5, 0, 0, 16'd3));
    vecs.push_back(mk(1, 7'd3,  0, 1, 4'd8, 0, 0, 16'd3));
    // beq taken, with one fetch wait cycle
    vecs.push_back(mk(1, 7'd99, 0, 0, 4'd0, 0, 0, 16'd4));
    vecs.push_back(mk(1, 7'd99, 0, 1, 4'd0, 1, 1, 16'd4));
    vecs.push_back(mk(1, 7'd99, 0, 1, 4'd1, 0, 0, 16'd4));
    vecs.push_back(mk(1, 7'd99, 1, 1, 4'd9, 1, 0, 16'd4));
    // beq not taken; mem_ready low in DECODE is ignored
    vecs.push_back(mk(1, 7'd99, 0, 1, 4'd0, 1, 1, 16'd5));
    vecs.push_back(mk(1, 7'd99, 0, 0, 4'd1, 0, 0, 16'd5));
    vecs.push_back(mk(1, 7'd99, 0, 1, 4'd9, 0, 0, 16'd5));
    // sw with one wait cycle in MEM_WR
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd0, 1, 1, 16'd6));
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd1, 0, 0, 16'd6));
    vecs.push_back(mk(1, 7'd35, 0, 0, 4'd4, 0, 0, 16'd6));
    vecs.push_back(mk(1, 7'd35, 0, 0, 4'd6, 0, 0, 16'd6));
    vecs.push_back(mk(1, 7'd35, 0, 1, 4'd6, 0, 0, 16'd6));
    // unsupported opcode
    vecs.push_back(mk(1, 7'h7F, 0, 1, 4'd0, 1, 1, 16'd7));
    vecs.push_back(mk(1, 7'h7F, 0, 1, 4'd1, 0, 0, 16'd7));
    vecs.push_back(mk(1, 7'h7F, 1, 1, 4'd15, 0, 0, 16'd7));

    rw_count = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
      if (i < 12 && reg_write === 1'b1) rw_count++;
    end
    checks++;
    if (rw_count != 2) begin
      errors++;
      $display("[TB] FAIL reg_write_count: got %0d expected 2", rw_count);
    end

    // TRAP is sticky with no strobes for 20 cycles
    for (int i = 0; i < 20; i++) begin
      v = mk(1'b1, 7'h7F, i[0], 1'b1, 4'd15, 1'b0, 1'b0, 16'd7);
      applyStimulus(v);
      checkOutput(v, $sformatf("trap%0d", i));
    end

    // Asynchronous reset leaves TRAP immediately
    rst = 1'b0;
    #1;
    checkOutput(mk(1'b0, 7'h7F, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0), "trap_reset");

    // 17 branches: the 4-bit counter wraps to 1
    for (int k = 0; k < 17; k++) begin
      v = mk(1'b1, 7'd99, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 16'(k));
      applyStimulus(v);
      checkOutput(v, $sformatf("beq%0d_f", k));
      v = mk(1'b1, 7'd99, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 16'(k));
      applyStimulus(v);
      checkOutput(v, $sformatf("beq%0d_d", k));
      v = mk(1'b1, 7'd99, k[0], 1'b1, 4'd9, k[0], 1'b0, 16'(k));
      applyStimulus(v);
      checkOutput(v, $sformatf("beq%0d_b", k));
    end

    // sw aborted by reset during MEM_WR
    v = mk(1'b1, 7'd35, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 16'd17);
    applyStimulus(v); checkOutput(v, "wrap_fetch");
    v = mk(1'b1, 7'd35, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 16'd17);
    applyStimulus(v); checkOutput(v, "abort_d");
    v = mk(1'b1, 7'd35, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 16'd17);
    applyStimulus(v); checkOutput(v, "abort_ma");
    v = mk(1'b1, 7'd35, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 16'd17);
    applyStimulus(v); checkOutput(v, "abort_mw");
    rst = 1'b0;
    #1;
    checkOutput(mk(1'b0, 7'd35, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0), "abort_reset");

    // Counting restarts from zero after the abort
    v = mk(1'b1, 7'd99, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 16'd0);
    applyStimulus(v); checkOutput(v, "restart_f");
    v = mk(1'b1, 7'd99, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 16'd0);
    applyStimulus(v); checkOutput(v, "restart_d");
    v = mk(1'b1, 7'd99, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 16'd0);
    applyStimulus(v); checkOutput(v, "restart_b");
    v = mk(1'b1, 7'd19, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1);
    applyStimulus(v); checkOutput(v, "restart_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller that turns the single-cycle RISC-V datapath (fetch/decode/execute/memory/writeback, unified instruction/data memory) into a multi-cycle machine. A Moore FSM, with handshake-qualified Mealy strobes, steps each instruction through FETCH → DECODE → execute-class states. It drives the per-cycle enables and mux selects, and waits on a variable-latency memory `mem_ready` handshake. It also counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `opcode`  in  7  `inst[6:0]` of the instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_write`  out  1  load PC from `pcsource` mux.
- `ir_write`  out  1  load instruction register and old_pc register (old_pc ← PC).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut register.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register bank write.
- `memtoreg`  out  1  write data select: 0 = ALUOut, 1 = memory data register.
- `alusrc_a`  out  2  ALU A select: 0 = PC, 1 = rs1 data, 2 = old_pc.
- `alusrc_b`  out  2  ALU B select: 0 = rs2 data, 1 = constant 4, 2 = ImmGen.
- `aluop`  out  2  to alucontrol: 0 = add/funct3-immediate, 1 = sub, 2 = funct decode.
- `pcsource`  out  1  PC input: 0 = ALU result (combinational), 1 = ALUOut register.
- `halted`  out  1  FSM is in TRAP.
- `state`  out  4  current state encoding, for debug.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5, MEM_WR = 6, WB_ALU = 7, WB_MEM = 8, BRANCH = 9, TRAP = 15.
- Default for all strobes is 0; default for all selects is 0 unless listed below.
- FETCH:
  - `mem_read` = 1, `iord` = 0, `alusrc_a` = 0, `alusrc_b` = 1, `aluop` = 0, `pcsource` = 0.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Goes to DECODE when `mem_ready`; otherwise stays in FETCH.
- DECODE:
  - `alusrc_a` = 2, `alusrc_b` = 2, `aluop` = 0. This precomputes the branch target old_pc + imm into ALUOut.
  - Dispatch on `opcode`: 51 → EXEC_R; 19 → EXEC_I; 3 or 35 → MEM_ADDR; 99 → BRANCH; any other value → TRAP.
- EXEC_R: `alusrc_a` = 1, `alusrc_b` = 0, `aluop` = 2; goes to WB_ALU.
- EXEC_I: `alusrc_a` = 1, `alusrc_b` = 2, `aluop` = 0; goes to WB_ALU.
- MEM_ADDR: `alusrc_a` = 1, `alusrc_b` = 2, `aluop` = 0; goes to MEM_RD if opcode is 3, to MEM_WR if opcode is 35.
- MEM_RD: `mem_read` = 1, `iord` = 1; stays until `mem_ready`, then goes to WB_MEM.
- MEM_WR: `mem_write` = 1, `iord` = 1; stays until `mem_ready`, then goes to FETCH and retires.
- WB_ALU: `reg_write` = 1, `memtoreg` = 0; goes to FETCH and retires.
- WB_MEM: `reg_write` = 1, `memtoreg` = 1; goes to FETCH and retires.
- BRANCH: `alusrc_a` = 1, `alusrc_b` = 0, `aluop` = 1, `pcsource` = 1, `pc_write` = `zero`; goes to FETCH and retires.
- TRAP: all strobes 0, `halted` = 1; sticky until `rst` is asserted.
- `retired` increments by 1 on every clock edge that leaves a retiring state toward FETCH. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (`rst` = 0, asynchronous): state = FETCH, `retired` = 0, `halted` = 0. All outputs take FETCH values immediately: `mem_read` = 1, `alusrc_b` = 1; `pc_write` and `ir_write` follow `mem_ready`.
  - While `rst` = 0, `pc_write` and `ir_write` are forced to 0.
  - Reset asserted mid-instruction aborts it with no retire; any write strobe drops in the same cycle.
- Latency with `mem_ready` tied high: R-type or I-type = 4 cycles, lw = 5, sw = 4, beq = 3.
  - Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Handshake: `mem_read`/`mem_write` and `iord` are held constant until the cycle in which `mem_ready` = 1.
  - The transfer completes on that rising edge.
  - `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- `zero` is sampled only in BRANCH, same cycle.
- `opcode` must be stable from DECODE until the return to FETCH; the instruction register guarantees this.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `mem_ready` = 1 → `state` = 0, `retired` = 0, `pc_write` = `ir_write` = 0. Release reset → `ir_write` = 1 in the first cycle.
- `mem_ready` = 1; opcode sequence 19, 51, 35 → states 0,1,3,7 | 0,1,2,7 | 0,1,4,6. `retired` = 3 after 12 cycles; `reg_write` is high exactly twice.
- lw (opcode 3) with `mem_ready` low for 2 cycles in MEM_RD → MEM_RD lasts 3 cycles with `iord` = 1 and `mem_read` = 1 throughout. The instruction takes 7 cycles; `reg_write` and `memtoreg` are high in WB_MEM.
- beq (opcode 99): `zero` = 1 → `pc_write` = 1, `pcsource` = 1 in BRANCH. `zero` = 0 → `pc_write` = 0. Both cases take 3 cycles and increment `retired`.
- Opcode 0x7F → TRAP, `halted` = 1, no further strobes for 20 cycles. Assert `rst` → FETCH, `halted` = 0.
- `CNT_W` = 4, 17 beq instructions → `retired` = 1 (wrap). `rst` pulsed during MEM_WR → `mem_write` drops immediately and `retired` = 0.
